// File: rtl/tile_sel_sequencer.sv
// Tile select sequencer: switches which of four tiles is clocked and released from
// reset. A switch gates every tile for GAP_CYCLES, then clocks the new tile in reset
// for RST_CYCLES, then releases it. sel only moves while no tile clock is enabled.
module tile_sel_sequencer #(
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned RST_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_sel,
   input  logic       req_valid,
   output logic       req_ready,
   output logic [1:0] sel,
   output logic [3:0] tile_clk_en,
   output logic [3:0] tile_rst_n,
   output logic       active
);

   typedef enum logic [1:0] {StGate, StHold, StRun} state_e;

   localparam logic [7:0] GapLoad = 8'(GAP_CYCLES - 1);
   localparam logic [7:0] RstLoad = 8'(RST_CYCLES - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] pend_q, pend_d;
   logic [3:0] sel_onehot;

   // State register; reset starts the power-up HOLD of tile 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StHold;
         cnt_q   <= RstLoad;
         sel_q   <= 2'd0;
         pend_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         pend_q  <= pend_d;
      end
   end

   // Next-state: accept only in RUN, then walk GATE -> HOLD -> RUN on counter expiry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      pend_d  = pend_q;
      unique case (state_q)
         StRun: begin
            // A request for the already selected tile is a no-op.
            if (req_valid && (req_sel != sel_q)) begin
               pend_d  = req_sel;
               cnt_d   = GapLoad;
               state_d = StGate;
            end
         end
         StGate: begin
            if (cnt_q == 8'd0) begin
               sel_d   = pend_q;
               cnt_d   = RstLoad;
               state_d = StHold;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StHold: begin
            if (cnt_q == 8'd0) begin
               state_d = StRun;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            // Unused encoding recovers through a fresh HOLD of the current tile.
            cnt_d   = RstLoad;
            state_d = StHold;
         end
      endcase
   end

   assign sel_onehot = 4'b0001 << sel_q;
   assign sel        = sel_q;

   // Outputs decode from state and sel only; rst_n masks them during reset.
   always_comb begin
      tile_clk_en = 4'b0000;
      tile_rst_n  = 4'b0000;
      active      = 1'b0;
      req_ready   = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            StGate: begin
               tile_clk_en = 4'b0000;
            end
            StHold: begin
               tile_clk_en = sel_onehot;
            end
            StRun: begin
               tile_clk_en = sel_onehot;
               tile_rst_n  = sel_onehot;
               active      = 1'b1;
               req_ready   = 1'b1;
            end
            default: begin
               tile_clk_en = 4'b0000;
            end
         endcase
      end
   end

endmodule
